// File: rtl/vector_pkg.sv
// Shared definitions for the vector display path: frame-buffer state
// encoding and the field layout of an 18-bit vector word.
package vector_pkg;

    typedef enum logic [1:0] {
        VFB_EMPTY   = 2'd0,
        VFB_RUN     = 2'd1,
        VFB_PENDING = 2'd2
    } vfb_state_t;

    localparam int Y_MSB    = 17;
    localparam int Y_LSB    = 10;
    localparam int X_MSB    = 9;
    localparam int X_LSB    = 2;
    localparam int LINE_BIT = 1;
    localparam int POS_BIT  = 0;

    // Build a vector word from its fields.
    function automatic logic [17:0] vfb_pack(input logic [7:0] y, input logic [7:0] x,
                                             input logic line, input logic pos);
        logic [17:0] w;
        w                = 18'd0;
        w[Y_MSB:Y_LSB]   = y;
        w[X_MSB:X_LSB]   = x;
        w[LINE_BIT]      = line;
        w[POS_BIT]       = pos;
        return w;
    endfunction

endpackage

// File: rtl/vector_frame_buffer_if.sv
// Host-write and display-read signals of the vector frame buffer.
// master = host/display side, slave = the frame buffer.
interface vector_frame_buffer_if #(
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 18
);
    logic                    wr_en;
    logic [ADDRESSWIDTH-1:0] wr_addr;
    logic [DATAWIDTH-1:0]    wr_data;
    logic                    wr_ready;
    logic                    commit;
    logic                    commit_pending;
    logic                    swap_done;
    logic                    front_sel;
    logic                    halt;
    logic [ADDRESSWIDTH-1:0] rd_addr;
    logic [DATAWIDTH-1:0]    rd_data;
    logic                    go_master;

    modport master (
        output wr_en, wr_addr, wr_data, commit, halt, rd_addr,
        input  wr_ready, commit_pending, swap_done, front_sel, rd_data, go_master
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, halt, rd_addr,
        output wr_ready, commit_pending, swap_done, front_sel, rd_data, go_master
    );
endinterface

// File: rtl/vfb_bank.sv
// One bank of vector memory: simple dual-port synchronous RAM with a
// registered read port. Storage has no reset so it maps onto block RAM.
module vfb_bank #(
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 18
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDRESSWIDTH-1:0] waddr,
    input  logic [DATAWIDTH-1:0]    wdata,
    input  logic [ADDRESSWIDTH-1:0] raddr,
    output logic [DATAWIDTH-1:0]    rdata
);
    logic [DATAWIDTH-1:0] mem_r [2**ADDRESSWIDTH];
    logic [DATAWIDTH-1:0] rdata_r;

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/vector_frame_buffer.sv
// Double-buffered vector list memory. The host fills the back bank; a commit
// is held until the display reaches a frame boundary (rising edge of halt),
// then the banks swap. The very first commit swaps immediately.
module vector_frame_buffer
    import vector_pkg::*;
#(
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vector_frame_buffer_if.slave bus
);
    vfb_state_t           state_r;
    vfb_state_t           state_next_s;
    logic                 swap_s;
    logic                 wr_accept_s;
    logic                 boundary_s;
    logic                 halt_d_r;
    logic                 front_sel_r;
    logic                 front_sel_d_r;
    logic                 go_master_r;
    logic                 commit_pending_r;
    logic                 swap_done_r;
    logic                 wr_ready_r;
    logic                 rd_valid_r;
    logic                 we0_s;
    logic                 we1_s;
    logic [DATAWIDTH-1:0] q0_s;
    logic [DATAWIDTH-1:0] q1_s;

    assign boundary_s = bus.halt & ~halt_d_r;

    // Next-state, swap decision and write gating.
    always_comb begin
        state_next_s = state_r;
        swap_s       = 1'b0;
        wr_accept_s  = 1'b0;
        case (state_r)
            VFB_EMPTY: begin
                wr_accept_s = bus.wr_en;
                if (bus.commit) begin
                    swap_s       = 1'b1;
                    state_next_s = VFB_RUN;
                end else begin
                    state_next_s = VFB_EMPTY;
                end
            end
            VFB_RUN: begin
                wr_accept_s = bus.wr_en;
                if (bus.commit) begin
                    state_next_s = VFB_PENDING;
                end else begin
                    state_next_s = VFB_RUN;
                end
            end
            VFB_PENDING: begin
                if (boundary_s) begin
                    swap_s       = 1'b1;
                    state_next_s = VFB_RUN;
                end else begin
                    state_next_s = VFB_PENDING;
                end
            end
            default: begin
                state_next_s = VFB_EMPTY;
            end
        endcase
    end

    // State, bank select and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= VFB_EMPTY;
            halt_d_r         <= 1'b0;
            front_sel_r      <= 1'b0;
            front_sel_d_r    <= 1'b0;
            go_master_r      <= 1'b0;
            commit_pending_r <= 1'b0;
            swap_done_r      <= 1'b0;
            wr_ready_r       <= 1'b1;
            rd_valid_r       <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            halt_d_r         <= bus.halt;
            front_sel_r      <= front_sel_r ^ swap_s;
            front_sel_d_r    <= front_sel_r;
            go_master_r      <= (state_r != VFB_EMPTY);
            commit_pending_r <= (state_next_s == VFB_PENDING);
            swap_done_r      <= swap_s;
            wr_ready_r       <= (state_next_s != VFB_PENDING);
            rd_valid_r       <= 1'b1;
        end
    end

    // Host writes always target the bank the display is not reading.
    assign we0_s = wr_accept_s & front_sel_r;
    assign we1_s = wr_accept_s & ~front_sel_r;

    vfb_bank #(.ADDRESSWIDTH(ADDRESSWIDTH), .DATAWIDTH(DATAWIDTH)) u_bank0 (
        .clk   (clk),
        .we    (we0_s),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (bus.rd_addr),
        .rdata (q0_s)
    );

    vfb_bank #(.ADDRESSWIDTH(ADDRESSWIDTH), .DATAWIDTH(DATAWIDTH)) u_bank1 (
        .clk   (clk),
        .we    (we1_s),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (bus.rd_addr),
        .rdata (q1_s)
    );

    // The select is delayed to line up with the bank read register, so the
    // word returned right after a swap still comes from the old front bank.
    // rd_valid_r forces zero until the first read after reset has completed.
    assign bus.rd_data        = rd_valid_r ? (front_sel_d_r ? q1_s : q0_s)
                                           : {DATAWIDTH{1'b0}};
    assign bus.wr_ready       = wr_ready_r;
    assign bus.commit_pending = commit_pending_r;
    assign bus.swap_done      = swap_done_r;
    assign bus.front_sel      = front_sel_r;
    assign bus.go_master      = go_master_r;
endmodule

// File: tb/tb_vector_frame_buffer.sv
// Directed bench for vector_frame_buffer. Inputs change 1 time unit after a
// rising edge; outputs are checked at the same point.
module tb_vector_frame_buffer;
    import vector_pkg::*;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   pass_cnt;
    int   swaps;

    vector_frame_buffer_if #(.ADDRESSWIDTH(8), .DATAWIDTH(18)) bus ();

    vector_frame_buffer #(.ADDRESSWIDTH(8), .DATAWIDTH(18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 8'd0;
        bus.wr_data    = 18'd0;
        bus.commit     = 1'b0;
        bus.halt       = 1'b0;
        bus.rd_addr    = 8'd0;
        tick();
        tick();
        // reset state
        chk("rst_front_sel", 32'(bus.front_sel), 32'd0);
        chk("rst_go_master", 32'(bus.go_master), 32'd0);
        chk("rst_pending",   32'(bus.commit_pending), 32'd0);
        chk("rst_swap_done", 32'(bus.swap_done), 32'd0);
        chk("rst_rd_data",   32'(bus.rd_data), 32'd0);
        chk("rst_wr_ready",  32'(bus.wr_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_go_master", 32'(bus.go_master), 32'd0);

        // first frame: addr 0..3 = 1..4, commit swaps at once
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 8'(i);
            bus.wr_data = 18'(i + 1);
            tick();
        end
        bus.wr_en  = 1'b0;
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        chk("first_front_sel", 32'(bus.front_sel), 32'd1);
        chk("first_swap_done", 32'(bus.swap_done), 32'd1);
        chk("first_go_early",  32'(bus.go_master), 32'd0);
        tick();
        chk("first_go_master", 32'(bus.go_master), 32'd1);
        chk("first_swap_once", 32'(bus.swap_done), 32'd0);
        bus.rd_addr = 8'd2;
        tick();
        chk("first_rd_addr2", 32'(bus.rd_data), 32'h00003);

        // pending commit blocks writes
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'd5;
        bus.wr_data = 18'h00055;
        tick();
        bus.wr_en  = 1'b0;
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        chk("pend_pending",  32'(bus.commit_pending), 32'd1);
        chk("pend_wr_ready", 32'(bus.wr_ready), 32'd0);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'd5;
        bus.wr_data = 18'h3FFFF;
        tick();
        bus.wr_en = 1'b0;
        chk("pend_no_swap", 32'(bus.front_sel), 32'd1);
        bus.halt = 1'b1;
        tick();
        chk("pend_swap_done", 32'(bus.swap_done), 32'd1);
        chk("pend_front_sel", 32'(bus.front_sel), 32'd0);
        chk("pend_cleared",   32'(bus.commit_pending), 32'd0);
        chk("pend_wr_ready1", 32'(bus.wr_ready), 32'd1);
        bus.halt = 1'b0;
        tick();
        chk("pend_swap_pulse", 32'(bus.swap_done), 32'd0);
        bus.rd_addr = 8'd5;
        tick();
        chk("pend_rd_addr5", 32'(bus.rd_data), 32'h00055);

        // halt held high while pending: one swap only
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        bus.halt   = 1'b1;
        swaps      = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.swap_done === 1'b1) swaps++;
        end
        chk("held_swaps", 32'(swaps), 32'd1);
        chk("held_front_sel", 32'(bus.front_sel), 32'd1);
        bus.halt = 1'b0;
        tick();
        bus.halt = 1'b1;
        swaps    = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.swap_done === 1'b1) swaps++;
        end
        bus.halt = 1'b0;
        chk("run_edge_swaps", 32'(swaps), 32'd0);
        chk("run_edge_front", 32'(bus.front_sel), 32'd1);

        // same-cycle write and commit
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'd7;
        bus.wr_data = vfb_pack(8'hAA, 8'hAA, 1'b1, 1'b0);
        bus.commit  = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        bus.commit  = 1'b0;
        chk("wc_pending", 32'(bus.commit_pending), 32'd1);
        bus.rd_addr = 8'd2;
        tick();
        bus.halt = 1'b1;
        tick();
        chk("wc_swap_done", 32'(bus.swap_done), 32'd1);
        chk("wc_front_sel", 32'(bus.front_sel), 32'd0);
        chk("wc_old_bank",  32'(bus.rd_data), 32'h00003);
        bus.halt    = 1'b0;
        bus.rd_addr = 8'd7;
        tick();
        chk("wc_rd_addr7", 32'(bus.rd_data), 32'h2AAAA);

        // same-cycle boundary and commit in RUN
        bus.halt   = 1'b1;
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        chk("bc_no_swap",  32'(bus.swap_done), 32'd0);
        chk("bc_pending",  32'(bus.commit_pending), 32'd1);
        chk("bc_front",    32'(bus.front_sel), 32'd0);
        tick();
        bus.halt = 1'b0;
        tick();
        chk("bc_still_pend", 32'(bus.commit_pending), 32'd1);
        chk("bc_no_swap2",   32'(bus.swap_done), 32'd0);
        bus.halt = 1'b1;
        tick();
        chk("bc_swap_done", 32'(bus.swap_done), 32'd1);
        chk("bc_front_sel", 32'(bus.front_sel), 32'd1);
        bus.halt = 1'b0;
        tick();

        // reset while pending
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        chk("rp_pending", 32'(bus.commit_pending), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rp_go_master", 32'(bus.go_master), 32'd0);
        chk("rp_front_sel", 32'(bus.front_sel), 32'd0);
        chk("rp_pend_clr",  32'(bus.commit_pending), 32'd0);
        chk("rp_wr_ready",  32'(bus.wr_ready), 32'd1);
        chk("rp_rd_data",   32'(bus.rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.halt = 1'b1;
        tick();
        chk("rp_no_swap",    32'(bus.swap_done), 32'd0);
        chk("rp_front_kept", 32'(bus.front_sel), 32'd0);
        tick();
        chk("rp_go_low", 32'(bus.go_master), 32'd0);
        bus.halt = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
